// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the view of the cache/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Port 0: instruction fetch, read-only
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              done0;
    // Port 1: data, read or write
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              wnext1;
    logic              gnt1;
    logic              rvalid1;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_ack,
        output gnt0, rvalid0, done0, wnext1, gnt1, rvalid1, done1, rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_ack,
        input  gnt0, rvalid0, done0, wnext1, gnt1, rvalid1, done1, rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing fixed-length, auto-incrementing bursts from two
// requesters onto one variable-latency memory port.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WORD_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid0;
    logic                r_rvalid1;

    logic                w_grant;
    logic                w_grant_port;
    logic                w_last_beat;
    logic                w_rd_ack;
    logic [ADDR_W-1:0]   w_addr;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_done0;
    logic                w_done1;
    logic                w_wnext1;
    logic                w_mem_req;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Byte address of a beat; the sum is truncated to ADDR_W so bursts wrap silently.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [BEAT_W-1:0] beat
    );
        beat_addr = base + (ADDR_W'(beat) * ADDR_W'(WORD_BYTES));
    endfunction

    assign w_addr      = beat_addr(r_base, r_beat);
    assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_rd_ack    = (r_state == ST_XFER) && bus.mem_ack && !r_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_grant_port = 1'b0;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        w_wnext1     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    if (bus.req0 && bus.req1) begin
                        w_grant_port = ~r_last_grant;
                    end else begin
                        w_grant_port = bus.req1;
                    end
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                w_gnt0     = ~r_owner;
                w_gnt1     = r_owner;
                w_mem_req  = 1'b1;
                w_mem_we   = r_we;
                w_mem_addr = w_addr;
                if (r_we) begin
                    w_mem_wdata = bus.wdata1;
                end
                if (bus.mem_ack) begin
                    w_wnext1 = r_we;
                    if (w_last_beat) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_gnt0  = ~r_owner;
                w_gnt1  = r_owner;
                w_done0 = ~r_owner;
                w_done1 = r_owner;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat       <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_rdata      <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd_ack && !r_owner;
            r_rvalid1 <= w_rd_ack && r_owner;
            if (w_rd_ack) begin
                r_rdata <= bus.mem_rdata;
            end
            if (w_grant) begin
                r_owner <= w_grant_port;
                r_we    <= w_grant_port ? bus.we1 : 1'b0;
                r_beat  <= '0;
            end else if ((r_state == ST_XFER) && bus.mem_ack && !w_last_beat) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (r_state == ST_DONE) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Base address is pure datapath and only meaningful after a grant.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_base <= w_grant_port ? bus.addr1 : bus.addr0;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.done0     = w_done0;
    assign bus.done1     = w_done1;
    assign bus.wnext1    = w_wnext1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, contention, writes, wrap, reset abort,
// stray ack and dropped request.
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    int   n_err;
    int   n_chk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},    bus_if.gnt0,    0);
        chk({tag, "_gnt1"},    bus_if.gnt1,    0);
        chk({tag, "_mem_req"}, bus_if.mem_req, 0);
        chk({tag, "_mem_we"},  bus_if.mem_we,  0);
        chk({tag, "_addr"},    bus_if.mem_addr, 0);
        chk({tag, "_rvalid0"}, bus_if.rvalid0, 0);
        chk({tag, "_rvalid1"}, bus_if.rvalid1, 0);
        chk({tag, "_done0"},   bus_if.done0,   0);
        chk({tag, "_done1"},   bus_if.done1,   0);
        chk({tag, "_rdata"},   bus_if.rdata,   0);
    endtask

    // Entered right after the grant edge; returns in the DONE cycle.
    task automatic xfer(input int p, input bit wr, input logic [31:0] base, input int gap,
                        input logic [31:0] dbase, input bit drop);
        logic [31:0] a;
        logic        wn;
        for (int b = 0; b < 4; b++) begin
            a = base + 32'(4 * b);
            for (int g = 0; g < gap; g++) begin
                chk("hold_req", bus_if.mem_req, 1);
                chk("hold_addr", bus_if.mem_addr, a);
                step();
            end
            chk("gnt0", bus_if.gnt0, p == 0);
            chk("gnt1", bus_if.gnt1, p == 1);
            chk("mem_req", bus_if.mem_req, 1);
            chk("mem_we", bus_if.mem_we, wr);
            chk("mem_addr", bus_if.mem_addr, a);
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = dbase + 32'(b);
            #1;
            chk("wnext1", bus_if.wnext1, wr);
            if (wr) chk("mem_wdata", bus_if.mem_wdata, 32'h11 * (b + 1));
            wn = bus_if.wnext1;
            step();
            bus_if.mem_ack = 1'b0;
            if (wn) bus_if.wdata1 = 32'h11 * (b + 2);
            if (drop && b == 0) bus_if.req0 = 1'b0;
            chk("rvalid0", bus_if.rvalid0, (p == 0) && !wr);
            chk("rvalid1", bus_if.rvalid1, (p == 1) && !wr);
            if (!wr) chk("rdata", bus_if.rdata, dbase + 32'(b));
            chk("done0", bus_if.done0, (p == 0) && (b == 3));
            chk("done1", bus_if.done1, (p == 1) && (b == 3));
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        reset_n          = 1'b0;
        bus_if.req0      = 1'b0;
        bus_if.addr0     = '0;
        bus_if.req1      = 1'b0;
        bus_if.we1       = 1'b0;
        bus_if.addr1     = '0;
        bus_if.wdata1    = '0;
        bus_if.mem_rdata = '0;
        bus_if.mem_ack   = 1'b0;

        // Reset state
        step();
        step();
        chk_all_zero("rst");
        reset_n = 1'b1;
        step();
        chk_all_zero("post_rst");

        // Single read burst on port 0
        bus_if.req0  = 1'b1;
        bus_if.addr0 = 32'h100;
        step();
        xfer(0, 0, 32'h100, 0, 32'hA0, 0);
        bus_if.req0 = 1'b0;
        step();
        chk("rd_idle_gnt0", bus_if.gnt0, 0);
        chk("rd_idle_rvalid0", bus_if.rvalid0, 0);
        chk("rd_idle_done0", bus_if.done0, 0);
        chk("rd_idle_rdata", bus_if.rdata, 32'hA3);

        // Contention from reset: 0,1,0,1
        reset_n = 1'b0;
        step();
        reset_n      = 1'b1;
        bus_if.req0  = 1'b1;
        bus_if.req1  = 1'b1;
        bus_if.addr0 = 32'h100;
        bus_if.addr1 = 32'h300;
        step();
        xfer(0, 0, 32'h100, 0, 32'h10, 0);
        step();
        chk("ct_idle_gnt0", bus_if.gnt0, 0);
        chk("ct_idle_gnt1", bus_if.gnt1, 0);
        step();
        xfer(1, 0, 32'h300, 0, 32'h20, 0);
        step();
        step();
        xfer(0, 0, 32'h100, 1, 32'h30, 0);
        step();
        step();
        xfer(1, 0, 32'h300, 0, 32'h40, 0);

        // Write burst on port 1, ack every third cycle
        bus_if.req0   = 1'b0;
        bus_if.we1    = 1'b1;
        bus_if.addr1  = 32'h200;
        bus_if.wdata1 = 32'h11;
        step();
        step();
        xfer(1, 1, 32'h200, 2, 32'h0, 0);
        bus_if.req1 = 1'b0;
        bus_if.we1  = 1'b0;
        step();
        chk("wr_rdata_hold", bus_if.rdata, 32'h43);
        chk("wr_idle_gnt1", bus_if.gnt1, 0);

        // Address wrap
        bus_if.req0  = 1'b1;
        bus_if.addr0 = 32'hFFFF_FFF8;
        step();
        xfer(0, 0, 32'hFFFF_FFF8, 0, 32'hB0, 0);
        bus_if.req0 = 1'b0;
        step();

        // Reset after the second ack aborts the burst
        bus_if.req0  = 1'b1;
        bus_if.addr0 = 32'h400;
        step();
        for (int b = 0; b < 2; b++) begin
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = 32'hC0 + 32'(b);
            step();
        end
        bus_if.mem_ack = 1'b0;
        chk("abort_pre_rvalid0", bus_if.rvalid0, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        bus_if.req1 = 1'b1;
        step();
        chk("abort_done0", bus_if.done0, 0);
        chk("abort_gnt0", bus_if.gnt0, 0);
        reset_n = 1'b1;
        step();
        xfer(0, 0, 32'h400, 0, 32'hD0, 0);
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        step();

        // Stray ack in IDLE
        step();
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hEE;
        step();
        bus_if.mem_ack = 1'b0;
        chk("stray_mem_req", bus_if.mem_req, 0);
        chk("stray_rvalid0", bus_if.rvalid0, 0);
        chk("stray_rvalid1", bus_if.rvalid1, 0);
        chk("stray_rdata", bus_if.rdata, 32'hD3);
        chk("stray_gnt0", bus_if.gnt0, 0);

        // Request dropped after the first beat still completes
        bus_if.req0  = 1'b1;
        bus_if.addr0 = 32'h500;
        step();
        xfer(0, 0, 32'h500, 0, 32'hF0, 1);
        step();
        chk("drop_done0", bus_if.done0, 0);
        chk("drop_gnt0", bus_if.gnt0, 0);
        step();
        chk("drop_no_regrant", bus_if.gnt0, 0);
        chk("drop_mem_req", bus_if.mem_req, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
